// File: rtl/discharge_pulse_scheduler_pkg.sv
// Shared definitions for the discharge pulse path (scheduler and i_set_generation).
package disch_pkg;

  localparam logic [15:0] WAVE_BUCK_CC_RECT = 16'h2001;
  localparam logic [15:0] WAVE_BUCK_CC_TRI  = 16'h2002;
  localparam logic [15:0] WAVE_BUCK_SC_RECT = 16'h6001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TON  = 2'd1,
    ST_TOFF = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True for the waveform codes the buck current loop knows how to generate.
  function automatic logic wave_valid(input logic [15:0] w);
    return (w == WAVE_BUCK_CC_RECT) || (w == WAVE_BUCK_CC_TRI) || (w == WAVE_BUCK_SC_RECT);
  endfunction

endpackage

// File: rtl/discharge_pulse_scheduler_if.sv
// Host-side control and buck-side timing signals of the pulse scheduler.
interface discharge_pulse_scheduler_if #(
  parameter int TIMER_W = 32,
  parameter int PH_W    = 1
);
  logic               start;
  logic               stop;
  logic [15:0]        waveform;
  logic [TIMER_W-1:0] Ton_timer;
  logic [TIMER_W-1:0] Toff_timer;
  logic [15:0]        pulse_num;
  logic               short_detect;
  logic [TIMER_W-1:0] timer_buck_interleave;
  logic               discharge_on;
  logic [PH_W-1:0]    phase_sel;
  logic [15:0]        pulse_cnt;
  logic               busy;
  logic               pulse_done;
  logic               param_err;

  modport master (
    output start, stop, waveform, Ton_timer, Toff_timer, pulse_num, short_detect,
    input  timer_buck_interleave, discharge_on, phase_sel, pulse_cnt, busy, pulse_done, param_err
  );

  modport slave (
    input  start, stop, waveform, Ton_timer, Toff_timer, pulse_num, short_detect,
    output timer_buck_interleave, discharge_on, phase_sel, pulse_cnt, busy, pulse_done, param_err
  );
endinterface

// File: rtl/discharge_pulse_scheduler_phase_rotator.sv
// Modulo-N_PHASE counter selecting the buck channel for the current pulse.
module phase_rotator #(
  parameter int N_PHASE = 2,
  parameter int PH_W    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            clear,
  output logic [PH_W-1:0] phase
);

  // Clear wins over advance; wrap to channel 0 after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       phase <= '0;
    else if (clear)   phase <= '0;
    else if (advance) phase <= (phase == PH_W'(N_PHASE - 1)) ? '0 : phase + PH_W'(1);
  end

endmodule

// File: rtl/discharge_pulse_scheduler.sv
// Discharge pulse train sequencer: Ton/Toff timing, pulse counting, buck phase rotation.
module discharge_pulse_scheduler
  import disch_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int N_PHASE = 2,
  parameter int PH_W    = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  discharge_pulse_scheduler_if.slave bus
);

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] ton_l, toff_l, timer, off_cnt;
  logic [15:0]        pnum_l, cnt, cnt_inc;
  logic               stop_pend, err;
  logic               accept, reject, ton_end, toff_end, advance;
  logic [PH_W-1:0]    phase;

  // Completed-pulse count saturates instead of wrapping.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign advance = toff_end && (state_nxt == ST_TON);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    ton_end   = 1'b0;
    toff_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A simultaneous stop cancels the start outright (no error flagged).
        if (bus.start && !bus.stop) begin
          if (wave_valid(bus.waveform) && (bus.Ton_timer != '0)) begin
            accept    = 1'b1;
            state_nxt = ST_TON;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_TON: begin
        // Short circuit truncates the on-time; the pulse still counts.
        if (bus.short_detect || (timer == ton_l)) begin
          ton_end   = 1'b1;
          state_nxt = ST_TOFF;
        end
      end
      ST_TOFF: begin
        // off_cnt starts at 1, so Toff=0 still yields one off cycle.
        if (off_cnt >= toff_l) begin
          toff_end = 1'b1;
          if (stop_pend || bus.stop || ((pnum_l != 16'd0) && (cnt_inc == pnum_l)))
            state_nxt = ST_DONE;
          else
            state_nxt = ST_TON;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latched train parameters, on/off timers, pulse counter and stop/error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ton_l     <= '0;
      toff_l    <= '0;
      pnum_l    <= '0;
      timer     <= '0;
      off_cnt   <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        ton_l     <= bus.Ton_timer;
        toff_l    <= bus.Toff_timer;
        pnum_l    <= bus.pulse_num;
        cnt       <= '0;
        stop_pend <= 1'b0;
        err       <= 1'b0;
        timer     <= TIMER_W'(1);
      end
      if (reject) err <= 1'b1;
      if (state == ST_TON) timer <= ton_end ? '0 : timer + TIMER_W'(1);
      if (ton_end)
        off_cnt <= TIMER_W'(1);
      else if ((state == ST_TOFF) && !toff_end)
        off_cnt <= off_cnt + TIMER_W'(1);
      if (toff_end) begin
        cnt <= cnt_inc;
        if (state_nxt == ST_TON) timer <= TIMER_W'(1);
      end
      if (((state == ST_TON) || (state == ST_TOFF)) && bus.stop) stop_pend <= 1'b1;
      if (state == ST_DONE) stop_pend <= 1'b0;
    end
  end

  phase_rotator #(.N_PHASE(N_PHASE), .PH_W(PH_W)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .clear   (accept),
    .phase   (phase)
  );

  assign bus.timer_buck_interleave = timer;
  assign bus.discharge_on          = (state == ST_TON);
  assign bus.phase_sel             = phase;
  assign bus.pulse_cnt             = cnt;
  assign bus.busy                  = (state == ST_TON) || (state == ST_TOFF);
  assign bus.pulse_done            = (state == ST_DONE);
  assign bus.param_err             = err;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Scoreboard bench: each train is expanded into a per-cycle expected trace from the
// pulse rules; a monitor pops one entry per clock and compares all outputs.
module tb_discharge_pulse_scheduler;
  import disch_pkg::*;

  localparam int TW = 32;
  localparam int NP = 3;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  discharge_pulse_scheduler_if #(.TIMER_W(TW), .PH_W(PW)) bus();

  discharge_pulse_scheduler #(.TIMER_W(TW), .N_PHASE(NP), .PH_W(PW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          on;
    logic [TW-1:0] tmr;
    logic [PW-1:0] ph;
    logic [15:0]   cnt;
    logic          busy;
    logic          done;
    logic          err;
  } exp_t;

  exp_t q[$];
  exp_t tr[$];
  bit   sh[$], sp[$], st[$];
  int   errors = 0;
  int   checks = 0;
  logic [15:0] m_cnt = '0;
  int   m_phase = 0;
  logic m_err = 1'b0;

  function automatic exp_t mk(logic on, int tmr, int ph, int cnt, logic busy, logic done, logic err);
    exp_t e;
    e.on = on; e.tmr = TW'(tmr); e.ph = PW'(ph); e.cnt = 16'(cnt);
    e.busy = busy; e.done = done; e.err = err;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(1'b0, 0, m_phase, int'(m_cnt), 1'b0, 1'b0, m_err);
  endfunction

  function automatic exp_t cur();
    exp_t a;
    a.on = bus.discharge_on; a.tmr = bus.timer_buck_interleave; a.ph = bus.phase_sel;
    a.cnt = bus.pulse_cnt; a.busy = bus.busy; a.done = bus.pulse_done; a.err = bus.param_err;
    return a;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("on=%b tmr=%0d ph=%0d cnt=%0d busy=%b done=%b err=%b",
                     e.on, e.tmr, e.ph, e.cnt, e.busy, e.done, e.err);
  endfunction

  task automatic chk(string name, exp_t a, exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t actual {%s} required {%s}", name, $time, fmt(a), fmt(e));
    end
  endtask

  // Monitor: one expected entry per clock, sampled after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cycle_state", cur(), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs and post what the outputs must show after the next edge.
  task automatic cyc(bit s, bit p, bit shd, exp_t e, bit scr);
    bus.start = s; bus.stop = p; bus.short_detect = shd;
    if (scr) begin
      bus.Ton_timer  = TW'($urandom_range(0, 15));
      bus.Toff_timer = TW'($urandom_range(0, 15));
      bus.waveform   = 16'($urandom);
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, idle_exp(), 0);
  endtask

  task automatic add(exp_t e, bit s_h, bit s_p, bit rs);
    tr.push_back(e); sh.push_back(s_h); sp.push_back(s_p);
    st.push_back(rs && ($urandom_range(0, 7) == 0));
  endtask

  // Expand a train into its cycle-by-cycle expected outputs and the matching
  // short/stop stimulus. stop goes on the first on-cycle of stop_p (or the last off-cycle).
  task automatic gen(int ton, int toff, int pnum, int short_p, int short_t,
                     int stop_p, bit stop_late, bit rs);
    int cnt, ph, n;
    bit brk;
    cnt = 0; ph = 0;
    tr.delete(); sh.delete(); sp.delete(); st.delete();
    for (int p = 0; p < 64; p++) begin
      ph = p % NP;
      for (int t = 1; t <= ton; t++) begin
        brk = (p == short_p) && (t == short_t);
        add(mk(1, t, ph, cnt, 1, 0, 0), brk, (p == stop_p) && (t == 1) && !stop_late, rs);
        if (brk) break;
      end
      n = (toff == 0) ? 1 : toff;
      for (int k = 1; k <= n; k++)
        add(mk(0, 0, ph, cnt, 1, 0, 0), 0, (p == stop_p) && stop_late && (k == n), rs);
      cnt = (cnt == 65535) ? cnt : cnt + 1;
      if ((p == stop_p) || ((pnum != 0) && (cnt == pnum))) begin
        add(mk(0, 0, ph, cnt, 0, 1, 0), 0, 0, 0);
        break;
      end
    end
    m_cnt = 16'(cnt); m_phase = ph; m_err = 1'b0;
  endtask

  task automatic run(logic [15:0] w, int ton, int toff, int pnum, int short_p, int short_t,
                     int stop_p, bit stop_late, bit rs, int abort_at);
    bit ok;
    int len;
    bus.waveform = w; bus.Ton_timer = TW'(ton); bus.Toff_timer = TW'(toff); bus.pulse_num = 16'(pnum);
    ok = ((w == 16'h2001) || (w == 16'h2002) || (w == 16'h6001)) && (ton != 0);
    if (!ok) begin
      m_err = 1'b1;
      cyc(1, 0, 0, idle_exp(), 0);
      cyc(0, 0, 0, idle_exp(), 0);
      return;
    end
    gen(ton, toff, pnum, short_p, short_t, stop_p, stop_late, rs);
    len = tr.size();
    cyc(1, 0, 0, tr[0], 0);
    for (int j = 0; j < len; j++) begin
      if (j == abort_at) return;
      cyc((j < len - 1) ? st[j] : 1'b0, sp[j], sh[j],
          (j + 1 < len) ? tr[j + 1] : idle_exp(), (j + 1 < len - 1) && rs);
    end
  endtask

  initial begin
    logic [15:0] w;
    int ton, toff, pnum, stp, shp, sht;
    bus.start = 0; bus.stop = 0; bus.short_detect = 0; bus.waveform = '0;
    bus.Ton_timer = '0; bus.Toff_timer = '0; bus.pulse_num = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", cur(), mk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    idle(2);

    // Two 5-cycle pulses with 3 off cycles: done on cycle 17, count 2.
    run(WAVE_BUCK_CC_RECT, 5, 3, 2, -1, 0, -1, 0, 0, -1);
    idle(2);
    // Continuous train stopped during the second on-time.
    run(WAVE_BUCK_CC_TRI, 4, 2, 0, -1, 0, 1, 0, 0, -1);
    idle(2);
    // Short at timer=3 truncates pulse 0; pulse 1 on phase 1.
    run(WAVE_BUCK_SC_RECT, 10, 2, 2, 0, 3, -1, 0, 0, -1);
    idle(2);
    // Rejected starts, start+stop in the same cycle, then a clearing valid start.
    run(16'h0001, 5, 1, 1, -1, 0, -1, 0, 0, -1);
    run(WAVE_BUCK_CC_RECT, 0, 1, 1, -1, 0, -1, 0, 0, -1);
    bus.Ton_timer = TW'(3);
    cyc(1, 1, 0, idle_exp(), 0);
    idle(1);
    run(WAVE_BUCK_CC_RECT, 3, 1, 1, -1, 0, -1, 0, 0, -1);
    idle(2);
    // Phase wrap with Toff=0 (single off cycle).
    run(WAVE_BUCK_CC_TRI, 2, 0, 4, -1, 0, -1, 0, 0, -1);
    idle(2);

    // Asynchronous reset in the cycle showing timer=7.
    run(WAVE_BUCK_CC_RECT, 10, 2, 1, -1, 0, -1, 0, 0, 6);
    rst_n = 1'b0;
    #1;
    chk("async_reset", cur(), mk(0, 0, 0, 0, 0, 0, 0));
    m_cnt = '0; m_phase = 0; m_err = 1'b0;
    bus.start = 0; bus.stop = 0; bus.short_detect = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    run(WAVE_BUCK_CC_RECT, 5, 3, 2, -1, 0, -1, 0, 0, -1);
    idle(2);

    // Randomized trains with mid-train parameter churn and ignored starts.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0:       w = 16'($urandom);
        1, 2, 3: w = WAVE_BUCK_CC_RECT;
        4, 5, 6: w = WAVE_BUCK_CC_TRI;
        default: w = WAVE_BUCK_SC_RECT;
      endcase
      ton  = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 6));
      toff = int'($urandom_range(0, 4));
      pnum = int'($urandom_range(0, 4));
      stp  = (pnum == 0) ? int'($urandom_range(0, 3))
                         : (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
      shp = -1; sht = 0;
      if ((ton > 0) && ($urandom_range(0, 1) == 1)) begin
        shp = int'($urandom_range(0, 3));
        sht = int'($urandom_range(1, ton));
      end
      if ($urandom_range(0, 7) == 0) cyc(1, 1, 0, idle_exp(), 0);
      run(w, ton, toff, pnum, shp, sht, stp, 1'($urandom_range(0, 1)), 1, -1);
      idle(int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
